aes_shift_rows_stream: RTL and testbench

//   Parametrised, handshaked (Inv)ShiftRows stage for the AES/Rijndael datapath.
//   Per-beat mode bit selects forward ShiftRows (encrypt) or InvShiftRows (decrypt).

---
 rtl/aes_shift_rows_stream.sv | 90 +++++++++
 tb/tb_aes_shift_rows_stream.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows_stream.sv
// AES/Rijndael (Inv)ShiftRows stage for NB = 4/6/8 columns.
// The transform is applied on accept; results queue in a 2-entry FIFO.
module aes_shift_rows_stream #(
   parameter int NB = 4,
   parameter int W  = 32*NB
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_decrypt,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_decrypt,
   output logic [1:0]   occupancy
);

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $fatal(1, "aes_shift_rows_stream: NB must be 4, 6 or 8");
   end

   // Row 2/3 offsets grow by one for the 256-bit block.
   function automatic int row_off(input int r);
      int s;
      s = r;
      if (NB == 8 && r >= 2) s = r + 1;
      return s;
   endfunction

   logic [W-1:0] w_fwd;
   logic [W-1:0] w_inv;
   logic [W-1:0] w_shift;

   for (genvar gc = 0; gc < NB; gc++) begin : g_col
      for (genvar gr = 0; gr < 4; gr++) begin : g_row
         localparam int S    = row_off(gr);
         localparam int DST  = 4*gc + gr;
         localparam int FSRC = 4*((gc + S) % NB) + gr;
         localparam int ISRC = 4*((gc + NB - S) % NB) + gr;
         assign w_fwd[W-1-8*DST -: 8] = in_data[W-1-8*FSRC -: 8];
         assign w_inv[W-1-8*DST -: 8] = in_data[W-1-8*ISRC -: 8];
      end
   end

   assign w_shift = in_decrypt ? w_inv : w_fwd;

   logic [W-1:0] r_mem [2];
   logic         r_dec [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_cnt;
   logic         w_push;
   logic         w_pop;

   assign in_ready    = (r_cnt != 2'd2);
   assign out_valid   = (r_cnt != 2'd0);
   assign occupancy   = r_cnt;
   assign out_data    = r_mem[r_rptr];
   assign out_decrypt = r_dec[r_rptr];

   assign w_push = in_valid & in_ready;
   assign w_pop  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
            r_dec[i] <= 1'b0;
         end
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_cnt  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_shift;
            r_dec[r_wptr] <= in_decrypt;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_shift_rows_stream.sv
// Directed bench for aes_shift_rows_stream (NB=4 and NB=8 builds).
// Hand vectors for the NB=4 cases; a row/column model for streams.
module tb_aes_shift_rows_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, in_decrypt;
   logic [127:0] in_data, out_data;
   logic         out_valid, out_ready, out_decrypt;
   logic [1:0]   occupancy;

   logic         in_valid8, in_ready8, in_decrypt8;
   logic [255:0] in_data8, out_data8;
   logic         out_valid8, out_ready8, out_decrypt8;
   logic [1:0]   occupancy8;

   aes_shift_rows_stream #(.NB(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_decrypt(in_decrypt),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_decrypt(out_decrypt),
      .occupancy(occupancy)
   );

   aes_shift_rows_stream #(.NB(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data8), .in_decrypt(in_decrypt8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .out_data(out_data8), .out_decrypt(out_decrypt8),
      .occupancy(occupancy8)
   );

   localparam logic [127:0] VIN  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] VFWD = 128'h00050a0f_04090e03_080d0207_0c01060b;
   localparam logic [127:0] VINV = 128'h000d0a07_04010e0b_0805020f_0c090603;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Row/column reference; state right-aligned in 32*nb bits.
   function automatic logic [255:0] ref_shift(input logic [255:0] s,
                                              input int nb, input bit inv);
      logic [7:0]   b [32];
      logic [255:0] o;
      int off, src;
      for (int i = 0; i < 4*nb; i++) b[i] = s[32*nb-1-8*i -: 8];
      o = '0;
      for (int c = 0; c < nb; c++) begin
         for (int r = 0; r < 4; r++) begin
            off = (r < 2) ? r : ((nb == 8) ? r + 1 : r);
            src = inv ? (c - off + nb) % nb : (c + off) % nb;
            o[32*nb-1-8*(4*c+r) -: 8] = b[4*src+r];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] beat(input int i);
      logic [127:0] v;
      for (int j = 0; j < 16; j++) v[127-8*j -: 8] = 8'(i*37 + j*11 + 5);
      return v;
   endfunction

   logic [127:0] st_in  [16];
   logic [127:0] st_out [16];
   logic [255:0] v8, o8;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; in_data8 = '0; in_decrypt8 = 1'b0; out_ready8 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_occ", 256'(occupancy), 256'd0);
      check("rst_ovalid", 256'(out_valid), 256'd0);
      check("rst_iready", 256'(in_ready), 256'd1);
      check("rst_odata", 256'(out_data), 256'd0);
      check("rst_odec", 256'(out_decrypt), 256'd0);

      // 1: forward
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = VIN; in_decrypt = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("fwd_valid", 256'(out_valid), 256'd1);
      check("fwd_data", 256'(out_data), 256'(VFWD));
      check("fwd_dec", 256'(out_decrypt), 256'd0);
      check("fwd_occ", 256'(occupancy), 256'd1);

      // 2: inverse
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = VIN; in_decrypt = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("inv_valid", 256'(out_valid), 256'd1);
      check("inv_data", 256'(out_data), 256'(VINV));
      check("inv_dec", 256'(out_decrypt), 256'd1);

      // 3: back-pressure
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = VIN; in_decrypt = 1'b0;
      @(posedge clk); #1;
      in_data = VIN; in_decrypt = 1'b1;
      @(posedge clk); #1;
      in_data = VFWD; in_decrypt = 1'b1;
      @(negedge clk);
      check("bp_iready0", 256'(in_ready), 256'd0);
      check("bp_occ2", 256'(occupancy), 256'd2);
      check("bp_headA", 256'(out_data), 256'(VFWD));
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      check("bp_holdA", 256'(out_data), 256'(VFWD));
      check("bp_holdocc", 256'(occupancy), 256'd2);
      @(posedge clk);
      @(negedge clk);
      check("bp_iready1", 256'(in_ready), 256'd1);
      check("bp_occ1", 256'(occupancy), 256'd1);
      check("bp_headB", 256'(out_data), 256'(VINV));
      check("bp_decB", 256'(out_decrypt), 256'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("bp_occC", 256'(occupancy), 256'd1);
      check("bp_headC", 256'(out_data), 256'(VIN));
      check("bp_decC", 256'(out_decrypt), 256'd1);
      @(posedge clk);
      @(negedge clk);
      check("bp_empty", 256'(out_valid), 256'd0);

      // 4: streaming with alternating mode, then fed back
      for (int i = 0; i < 16; i++) st_in[i] = beat(i);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = st_in[0]; in_decrypt = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (i < 15) begin
            in_data = st_in[i+1]; in_decrypt = 1'((i+1) & 1);
         end else in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("st_valid%0d", i), 256'(out_valid), 256'd1);
         check($sformatf("st_dec%0d", i), 256'(out_decrypt), 256'(i & 1));
         check($sformatf("st_data%0d", i), 256'(out_data),
               ref_shift(256'(st_in[i]), 4, 1'(i & 1)));
         st_out[i] = out_data;
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = st_out[0]; in_decrypt = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (i < 15) begin
            in_data = st_out[i+1]; in_decrypt = 1'(~(i+1) & 1);
         end else in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("rt_data%0d", i), 256'(out_data), 256'(st_in[i]));
      end
      @(posedge clk);
      @(negedge clk);
      check("st_drained", 256'(occupancy), 256'd0);

      // 5: asynchronous reset with a full buffer
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = VIN; in_decrypt = 1'b1;
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("rs_full", 256'(occupancy), 256'd2);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("rs_ovalid", 256'(out_valid), 256'd0);
      check("rs_occ", 256'(occupancy), 256'd0);
      check("rs_iready", 256'(in_ready), 256'd1);
      check("rs_odata", 256'(out_data), 256'd0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("rs_stale%0d", k), 256'(out_valid), 256'd0);
      end

      // 6: NB=8 build
      for (int i = 0; i < 32; i++) v8[255-8*i -: 8] = 8'(i);
      @(posedge clk); #1;
      in_valid8 = 1'b1; in_data8 = v8; in_decrypt8 = 1'b0;
      @(posedge clk); #1 in_valid8 = 1'b0;
      @(negedge clk);
      o8 = out_data8;
      check("nb8_valid", 256'(out_valid8), 256'd1);
      check("nb8_r1c0", 256'(o8[255-8*1 -: 8]), 256'h05);
      check("nb8_r2c0", 256'(o8[255-8*2 -: 8]), 256'h0e);
      check("nb8_r3c0", 256'(o8[255-8*3 -: 8]), 256'h13);
      check("nb8_full", o8, ref_shift(v8, 8, 1'b0));
      @(posedge clk); #1;
      in_valid8 = 1'b1; in_data8 = o8; in_decrypt8 = 1'b1;
      @(posedge clk); #1 in_valid8 = 1'b0;
      @(negedge clk);
      check("nb8_rt", out_data8, v8);
      check("nb8_rtdec", 256'(out_decrypt8), 256'd1);
      @(posedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
